// File: rtl/gemm_row_pipe_if.sv
// Handshake and row-data bundle between the GEMM buffer read ports, the MAC row
// and the accumulator write-back. The master drives beats in and consumes results.
interface gemm_row_pipe_if #(
    parameter int LANES     = 16,
    parameter int INP_WIDTH = 8,
    parameter int WGT_WIDTH = 8,
    parameter int ACC_WIDTH = 32
);
    logic                          in_valid;
    logic                          in_ready;
    logic                          in_clr;
    logic [LANES-1:0]              in_mask;
    logic [LANES*INP_WIDTH-1:0]    i_row;
    logic [LANES*WGT_WIDTH-1:0]    w_row;
    logic [LANES*ACC_WIDTH-1:0]    a_row;
    logic                          out_valid;
    logic                          out_ready;
    logic [LANES*ACC_WIDTH-1:0]    o_row;

    modport master (
        output in_valid, in_clr, in_mask, i_row, w_row, a_row, out_ready,
        input  in_ready, out_valid, o_row
    );

    modport slave (
        input  in_valid, in_clr, in_mask, i_row, w_row, a_row, out_ready,
        output in_ready, out_valid, o_row
    );
endinterface

// File: rtl/gemm_row_pipe.sv
// Two-stage pipelined row of LANES signed MACs (o = a + i*w) with valid/ready
// backpressure, per-beat accumulator clear and per-lane write mask.
module gemm_row_pipe #(
    parameter int LANES     = 16,
    parameter int INP_WIDTH = 8,
    parameter int WGT_WIDTH = 8,
    parameter int ACC_WIDTH = 32,
    parameter int USE_DSP   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    gemm_row_pipe_if.slave  bus
);
    localparam int PROD_WIDTH = INP_WIDTH + WGT_WIDTH;

    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_load, s2_load;
    logic in_xfer, s2_adv;

    // An empty stage always loads, so bubbles collapse even while the output stalls.
    always_comb begin
        s2_load    = !s2_valid_q || bus.out_ready;
        s1_load    = !s1_valid_q || s2_load;
        in_xfer    = bus.in_valid && s1_load;
        s2_adv     = s2_load && s1_valid_q;
        s1_valid_d = s1_load ? bus.in_valid : s1_valid_q;
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    end

    assign bus.in_ready  = s1_load;
    assign bus.out_valid = s2_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [ACC_WIDTH-1:0] prod_q, prod_d;
            logic signed [ACC_WIDTH-1:0] aeff_q, aeff_d;
            logic                        mask_q, mask_d;
            logic        [ACC_WIDTH-1:0] o_q, o_d;

            // The attribute only steers multiplier mapping; both branches compute the same product.
            if (USE_DSP != 0) begin : g_mul
                (* use_dsp = "yes" *) logic signed [PROD_WIDTH-1:0] mult;
                assign mult = $signed(bus.i_row[gi*INP_WIDTH +: INP_WIDTH]) *
                              $signed(bus.w_row[gi*WGT_WIDTH +: WGT_WIDTH]);
            end else begin : g_mul
                (* use_dsp = "no" *) logic signed [PROD_WIDTH-1:0] mult;
                assign mult = $signed(bus.i_row[gi*INP_WIDTH +: INP_WIDTH]) *
                              $signed(bus.w_row[gi*WGT_WIDTH +: WGT_WIDTH]);
            end

            always_comb begin
                prod_d = prod_q;
                aeff_d = aeff_q;
                mask_d = mask_q;
                o_d    = o_q;
                if (in_xfer) begin
                    prod_d = ACC_WIDTH'(g_mul.mult);
                    aeff_d = bus.in_clr ? '0 : $signed(bus.a_row[gi*ACC_WIDTH +: ACC_WIDTH]);
                    mask_d = bus.in_mask[gi];
                end
                if (s2_adv) begin
                    o_d = mask_q ? ACC_WIDTH'(aeff_q + prod_q) : ACC_WIDTH'(aeff_q);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prod_q <= '0;
                    aeff_q <= '0;
                    mask_q <= 1'b0;
                    o_q    <= '0;
                end else begin
                    prod_q <= prod_d;
                    aeff_q <= aeff_d;
                    mask_q <= mask_d;
                    o_q    <= o_d;
                end
            end

            assign bus.o_row[gi*ACC_WIDTH +: ACC_WIDTH] = o_q;
        end
    endgenerate
endmodule

// File: tb/tb_gemm_row_pipe.sv
// Self-checking bench for gemm_row_pipe: directed vector table, backpressure and
// reset sequences, plus randomized full-throughput traffic against a lane model.
module tb_gemm_row_pipe;
    localparam int LANES = 16;
    localparam int IW    = 8;
    localparam int WW    = 8;
    localparam int AW    = 32;
    localparam int ROW_W = LANES * AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gemm_row_pipe_if #(.LANES(LANES), .INP_WIDTH(IW), .WGT_WIDTH(WW), .ACC_WIDTH(AW)) bus ();

    gemm_row_pipe #(
        .LANES(LANES), .INP_WIDTH(IW), .WGT_WIDTH(WW), .ACC_WIDTH(AW), .USE_DSP(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [7:0]  i;
        logic [7:0]  w;
        logic [31:0] a;
        logic        clr;
        logic [15:0] mask;
        logic [31:0] exp_on;
        logic [31:0] exp_off;
        string       name;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc = 0;
    int n_out = 0;
    logic [ROW_W-1:0] exp_q[$];
    logic             prev_stall = 1'b0;
    logic [ROW_W-1:0] prev_o;

    task automatic check(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Lane-by-lane arithmetic from the datapath rules, using wide integers then truncating.
    function automatic logic [ROW_W-1:0] model(input logic [LANES*IW-1:0] ir,
                                               input logic [LANES*WW-1:0] wr,
                                               input logic [ROW_W-1:0] ar,
                                               input logic clr,
                                               input logic [LANES-1:0] mask);
        logic [ROW_W-1:0] o;
        o = '0;
        for (int l = 0; l < LANES; l++) begin
            longint ii, ww, aa, r;
            ii = longint'($signed(ir[l*IW +: IW]));
            ww = longint'($signed(wr[l*WW +: WW]));
            aa = clr ? 64'sd0 : longint'($signed(ar[l*AW +: AW]));
            r  = mask[l] ? aa + ii * ww : aa;
            o[l*AW +: AW] = r[AW-1:0];
        end
        return o;
    endfunction

    // Scoreboard: every accepted beat is modelled, every delivered beat is popped in order.
    initial begin : monitor
        logic [ROW_W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid_hold", ROW_W'(bus.out_valid), ROW_W'(1));
                    check("stall_row_hold", bus.o_row, prev_o);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL spurious_out: got %h required no beat", bus.o_row);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_row", bus.o_row, e);
                    end
                    n_out++;
                    $display("out beat %0d lane0=%h lane15=%h", n_out, bus.o_row[31:0], bus.o_row[ROW_W-1 -: AW]);
                end
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(model(bus.i_row, bus.w_row, bus.a_row, bus.in_clr, bus.in_mask));
                    n_acc++;
                    $display("in  beat %0d clr=%b mask=%h lane0 i=%0d w=%0d a=%h", n_acc, bus.in_clr,
                             bus.in_mask, $signed(bus.i_row[7:0]), $signed(bus.w_row[7:0]), bus.a_row[31:0]);
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_o     = bus.o_row;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bcast(input logic [7:0] i, input logic [7:0] w, input logic [31:0] a,
                               input logic clr, input logic [15:0] mask);
        logic [LANES*IW-1:0] ir;
        logic [LANES*WW-1:0] wr;
        logic [ROW_W-1:0]    ar;
        for (int l = 0; l < LANES; l++) begin
            ir[l*IW +: IW] = i;
            wr[l*WW +: WW] = w;
            ar[l*AW +: AW] = a;
        end
        bus.i_row   = ir;
        bus.w_row   = wr;
        bus.a_row   = ar;
        bus.in_clr  = clr;
        bus.in_mask = mask;
    endtask

    task automatic drive_random();
        logic [LANES*IW-1:0] ir;
        logic [LANES*WW-1:0] wr;
        logic [ROW_W-1:0]    ar;
        for (int l = 0; l < LANES; l++) begin
            ir[l*IW +: IW] = IW'($urandom);
            wr[l*WW +: WW] = WW'($urandom);
            ar[l*AW +: AW] = $urandom;
        end
        bus.i_row   = ir;
        bus.w_row   = wr;
        bus.a_row   = ar;
        bus.in_clr  = 1'($urandom_range(0, 1));
        bus.in_mask = 16'($urandom);
    endtask

    // One beat into an empty pipeline with out_ready high: output in the second cycle after
    // presentation, valid for exactly one cycle.
    task automatic run_vec(input vec_t v);
        logic [ROW_W-1:0] req;
        for (int l = 0; l < LANES; l++) req[l*AW +: AW] = v.mask[l] ? v.exp_on : v.exp_off;
        bus.out_ready = 1'b1;
        drive_bcast(v.i, v.w, v.a, v.clr, v.mask);
        bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        check({v.name, "_lat1_valid"}, ROW_W'(bus.out_valid), ROW_W'(0));
        cycle();
        check({v.name, "_lat2_valid"}, ROW_W'(bus.out_valid), ROW_W'(1));
        check({v.name, "_row"}, bus.o_row, req);
        cycle();
        check({v.name, "_one_cycle"}, ROW_W'(bus.out_valid), ROW_W'(0));
    endtask

    initial begin : stimulus
        vec_t             vecs[5];
        logic [ROW_W-1:0] req;
        int               acc0, out0, k, guard, t;

        vecs[0] = '{8'h03, 8'hFC, 32'd100,       1'b0, 16'hFFFF, 32'd88,        32'd88,  "basic"};
        vecs[1] = '{8'h80, 8'h80, 32'h7FFF_C001, 1'b0, 16'hFFFF, 32'h8000_0001, 32'd0,   "wrap_pos"};
        vecs[2] = '{8'h7F, 8'h80, 32'd0,         1'b0, 16'hFFFF, 32'hFFFF_C080, 32'd0,   "neg_prod"};
        vecs[3] = '{8'h02, 8'h05, 32'd500,       1'b1, 16'h00FF, 32'd10,        32'd0,   "mask_clr"};
        vecs[4] = '{8'h02, 8'h05, 32'd500,       1'b0, 16'h00FF, 32'd510,       32'd500, "mask_noclr"};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive_bcast(8'h00, 8'h00, 32'd0, 1'b0, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", ROW_W'(bus.out_valid), ROW_W'(0));
        check("rst_o_row", bus.o_row, '0);
        check("rst_in_ready", ROW_W'(bus.in_ready), ROW_W'(1));
        rst_n = 1'b1;
        cycle();

        for (int v = 0; v < 5; v++) run_vec(vecs[v]);

        // Backpressure: only two beats fit while the output is stalled.
        bus.out_ready = 1'b0;
        acc0 = n_acc;
        out0 = n_out;
        k    = 0;
        repeat (6) begin
            drive_bcast(8'd1, 8'd1, 32'(k), 1'b0, 16'hFFFF);
            bus.in_valid = 1'b1;
            cycle();
            k = n_acc - acc0;
        end
        check("bp_accepts", ROW_W'(k), ROW_W'(2));
        #1;
        check("bp_in_ready_low", ROW_W'(bus.in_ready), ROW_W'(0));
        check("bp_out_valid", ROW_W'(bus.out_valid), ROW_W'(1));
        for (int l = 0; l < LANES; l++) req[l*AW +: AW] = 32'd1;
        check("bp_hold_beat0", bus.o_row, req);

        guard = 0;
        t     = 0;
        while ((k < 6 || exp_q.size() != 0) && guard < 80) begin
            bus.out_ready = (t % 2 == 0);
            if (k < 6) begin
                drive_bcast(8'd1, 8'd1, 32'(k), 1'b0, 16'hFFFF);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            cycle();
            k = n_acc - acc0;
            t++;
            guard++;
        end
        bus.in_valid = 1'b0;
        check("bp_drain_bound", ROW_W'(guard < 80), ROW_W'(1));
        check("bp_out_count", ROW_W'(n_out - out0), ROW_W'(6));
        for (int l = 0; l < LANES; l++) req[l*AW +: AW] = 32'd6;
        check("bp_last_beat", bus.o_row, req);

        // Full throughput: 32 random beats back to back.
        bus.out_ready = 1'b1;
        cycle();
        acc0 = n_acc;
        out0 = n_out;
        for (int b = 0; b < 32; b++) begin
            drive_random();
            bus.in_valid = 1'b1;
            cycle();
        end
        bus.in_valid = 1'b0;
        check("tp_accepts", ROW_W'(n_acc - acc0), ROW_W'(32));
        cycle();
        check("tp_outs_minus1", ROW_W'(n_out - out0), ROW_W'(31));
        cycle();
        check("tp_outs", ROW_W'(n_out - out0), ROW_W'(32));

        // Reset with two beats in flight discards them.
        drive_random();
        bus.in_valid = 1'b1;
        cycle();
        drive_random();
        cycle();
        bus.in_valid = 1'b0;
        check("mid_two_in_flight", ROW_W'(bus.out_valid), ROW_W'(1));
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_out_valid", ROW_W'(bus.out_valid), ROW_W'(0));
        check("mid_rst_o_row", bus.o_row, '0);
        check("mid_rst_in_ready", ROW_W'(bus.in_ready), ROW_W'(1));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cycle();
        check("post_rst_quiet1", ROW_W'(bus.out_valid), ROW_W'(0));
        cycle();
        check("post_rst_quiet2", ROW_W'(bus.out_valid), ROW_W'(0));
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gemm_row_pipe.md
Name: gemm_row_pipe

Overview:
Parametrised, pipelined successor to the combinational 16-lane MAC row of the GEMM core.
- Computes LANES independent signed multiply-accumulates per beat: o = a + i*w.
- Has a valid/ready handshake, a 2-stage register pipeline with backpressure, a per-beat accumulator-bypass mode and a per-lane write mask.
- Sits between the input/weight/accumulator buffer read ports and the accumulator write-back in the GEMM core.

Parameters:
LANES, 16, number of MAC lanes
INP_WIDTH, 8, signed input element width
WGT_WIDTH, 8, signed weight element width
ACC_WIDTH, 32, signed accumulator width; must be >= INP_WIDTH+WGT_WIDTH
USE_DSP, 1, 1 = request DSP multipliers (synthesis attribute only); 0 = LUT multipliers; no functional difference

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_clr  in  1  beat-qualified: ignore a_row, treat accumulator as 0
in_mask  in  LANES  beat-qualified: 1 = lane computes, 0 = lane passes a_row through unchanged
i_row  in  LANES*INP_WIDTH  packed inputs, lane k at [k*INP_WIDTH +: INP_WIDTH]
w_row  in  LANES*WGT_WIDTH  packed weights, same packing
a_row  in  LANES*ACC_WIDTH  packed accumulators, same packing
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output
o_row  out  LANES*ACC_WIDTH  packed results

Behaviour:
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - in_clr, in_mask and all row data are sampled only on an input transfer.
- Stage 1 (S1) registers, per lane: product p = signed(i) * signed(w), sign-extended to ACC_WIDTH; a_eff = in_clr ? 0 : a; mask bit; plus s1_valid.
- Stage 2 (S2) registers, per lane: o = mask ? (a_eff + p) mod 2^ACC_WIDTH : a_eff; plus s2_valid. S2 drives o_row and out_valid directly from registers.
  - Masked-off lane with in_clr=1 outputs 0.
  - Overflow wraps silently. No saturation, no flags.
- Advance conditions:
  - S2 loads when !s2_valid || out_ready.
  - S1 loads when !s1_valid || S2 loads.
  - in_ready = !s1_valid || (!s2_valid || out_ready). This is combinational, with no path from in_valid.
- Latency and throughput:
  - Latency is exactly 2 cycles from input transfer to out_valid when unstalled.
  - Throughput is 1 beat/cycle while out_ready stays high.
- Bubbles: an empty stage is filled regardless of downstream stall (bubble collapse). With out_ready=0, the pipeline holds at most 2 beats, then in_ready=0.
- Stall hold: while out_valid && !out_ready, o_row and out_valid hold stable. Beats are never dropped, duplicated or reordered.
- Simultaneous output and input transfer in the same cycle while full: both occur; occupancy is unchanged.
- Reset (asynchronously on rst_n low):
  - s1_valid=0, s2_valid=0, out_valid=0, o_row=0, all S1 data regs = 0; hence in_ready=1 once valids clear.
  - Reset mid-stream discards in-flight beats. No output is produced for them after release.
- No X propagation from data ports when the corresponding valid is low. Datapath registers load only on advance, so o_row holds the last value when idle.

Test Plan:
1. Reset, then single beat, all lanes i=3, w=-4, a=100, clr=0, mask=all1s, out_ready=1 -> out_valid exactly 2 cycles later, every lane o=88, valid for 1 cycle.
2. Extremes: i=-128, w=-128, a=0x7FFFC001 -> o=0x80000001 (wrap); i=127, w=-128, a=0 -> o=0xFFFFC080.
3. Mask and clear: beat with mask=0x00FF, clr=1, a=500, i=2, w=5 -> lanes 0-7 o=10, lanes 8-15 o=0; same beat with clr=0 -> lanes 0-7 o=510, lanes 8-15 o=500.
4. Backpressure:
   - Stream 6 beats (a = beat index 0..5, i=w=1) with out_ready=0 -> in_ready drops after 2 accepts; o_row holds beat 0 (all lanes 1).
   - Then toggle out_ready 1,0,1,... -> outputs 1..6 in order, no loss or duplication.
5. Full-throughput: 32 back-to-back beats with random data, out_ready=1 -> 32 outputs on 32 consecutive cycles matching a reference model.
6. Reset mid-operation: assert rst_n=0 with 2 beats in flight, release -> out_valid=0, o_row=0, in_ready=1; the next beat is processed normally with 2-cycle latency.
